// File: rtl/ps2_scancode_rx_fifo_if.sv
// Read-side byte stream of the PS/2 scancode receiver.
// master: the receiver (drives head byte, valid and fill count).
// slave:  the consumer (drives ready).
interface ps2_scancode_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    code_data;
  logic          code_valid;
  logic          code_ready;
  logic [CW-1:0] fifo_count;

  modport master (
    output code_data,
    output code_valid,
    output fifo_count,
    input  code_ready
  );

  modport slave (
    input  code_data,
    input  code_valid,
    input  fifo_count,
    output code_ready
  );
endinterface

// File: rtl/ps2_scancode_rx_fifo.sv
// PS/2 device-to-host receiver feeding a scancode FIFO.
// Checks odd parity and the stop bit, aborts stalled frames after
// TIMEOUT_CYCLES without a PS/2 clock fall, and raises a level interrupt
// while the FIFO holds at least IRQ_THRESHOLD entries.
// Optional build macro PS2_BREAK_FILTER_EN: swallow 0xF0 and the byte
// that follows it, so only make codes reach the FIFO.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and parity, pushing the byte
module ps2_scancode_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int IRQ_THRESHOLD  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2k_clk,
  input  logic                          ps2k_data,
  ps2_scancode_rx_fifo_if.master        code,
  input  logic                          err_clr,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          interrupt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] IRQ_C    = CW'(IRQ_THRESHOLD);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    clk_sync_q, dat_sync_q;
  logic          fall, bit_in;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit, stop_ok, par_bad, stop_bad;
  logic          push, pop, full, wr_en, ovf_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    last_q;

  // Three-flop synchronisers; reset to the idle-high line level so release
  // of reset never looks like a clock fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2k_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2k_data};
    end
  end

  assign fall   = ~clk_sync_q[1] & clk_sync_q[2];
  assign bit_in = dat_sync_q[2];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and frame verdicts; a fall in the same cycle beats the timeout.
  always_comb begin
    state_d  = state_q;
    stop_ok  = 1'b0;
    par_bad  = 1'b0;
    stop_bad = 1'b0;
    tmo_hit  = (state_q != S_IDLE) && !fall && (tmo_q == '0);
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!bit_in) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          state_d  = S_IDLE;
          par_bad  = ~(^{shift_q, par_q});
          stop_bad = ~bit_in;
          stop_ok  = bit_in & (^{shift_q, par_q});
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Frame datapath: shift register, bit counter, parity latch, stall down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= TMO_LOAD;
    end else begin
      if (fall)
        tmo_q <= TMO_LOAD;
      else if (state_q != S_IDLE && tmo_q != '0)
        tmo_q <= tmo_q - 1'b1;
      if (fall) begin
        case (state_q)
          S_IDLE:   bit_cnt_q <= '0;
          S_DATA: begin
            shift_q   <= {bit_in, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          S_PARITY: par_q <= bit_in;
          default:  ;
        endcase
      end
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic drop_q;

  // Break prefix arms the drop flag; the next good byte consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_q <= 1'b0;
    else if (stop_ok)
      drop_q <= (shift_q == 8'hF0);
    else if (par_bad || stop_bad || tmo_hit)
      drop_q <= 1'b0;
  end

  assign push = stop_ok && (shift_q != 8'hF0) && !drop_q;
`else
  assign push = stop_ok;
`endif

  assign pop     = (count_q != '0) && code.code_ready;
  assign full    = (count_q == DEPTH_C);
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // Storage array; no reset needed since only counted entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  // Pointers wrap naturally; count disambiguates full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ovf_set)                overflow   <= 1'b1;
      else if (err_clr)           overflow   <= 1'b0;
      if (par_bad)                parity_err <= 1'b1;
      else if (err_clr)           parity_err <= 1'b0;
      if (stop_bad || tmo_hit)    frame_err  <= 1'b1;
      else if (err_clr)           frame_err  <= 1'b0;
    end
  end

  // When empty the head mux falls back to the last popped byte.
  assign code.code_data  = (count_q != '0) ? mem[rd_ptr_q] : last_q;
  assign code.code_valid = (count_q != '0);
  assign code.fifo_count = count_q;
  assign interrupt       = (count_q >= IRQ_C);
endmodule

// File: tb/tb_ps2_scancode_rx_fifo.sv
// Self-checking bench for ps2_scancode_rx_fifo: PS/2 frames are bit-banged
// on the pins, and a queue-based model of the FIFO and flags predicts results.
module tb_ps2_scancode_rx_fifo;
  localparam int DEPTH = 16;
  localparam int TMO   = 300;
  localparam int IRQ   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2k_clk = 1'b1;
  logic ps2k_data = 1'b1;
  logic code_ready = 1'b0;
  logic err_clr = 1'b0;
  logic overflow, parity_err, frame_err, interrupt;
  logic [7:0] code_data;
  logic       code_valid;
  logic [4:0] fifo_count;

  ps2_scancode_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) code_if ();
  assign code_if.code_ready = code_ready;
  assign code_data  = code_if.code_data;
  assign code_valid = code_if.code_valid;
  assign fifo_count = code_if.fifo_count;

  ps2_scancode_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .IRQ_THRESHOLD(IRQ)
  ) dut (
    .clk(clk), .rst(rst), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
    .code(code_if), .err_clr(err_clr), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO contents and expected sticky flags.
  logic [7:0] mq[$];
  bit exp_ovf = 0, exp_par = 0, exp_frm = 0, drop = 0;

  function automatic void model_frame(input logic [7:0] b, input bit bad_par,
                                      input bit bad_stop, input bit pop_at_push);
    logic [7:0] tmp;
    if (pop_at_push && mq.size() > 0) tmp = mq.pop_front();
    if (bad_par)  exp_par = 1;
    if (bad_stop) exp_frm = 1;
    if (bad_par || bad_stop) begin
      drop = 0;
      return;
    end
`ifdef PS2_BREAK_FILTER_EN
    if (b == 8'hF0) begin drop = 1; return; end
    if (drop)       begin drop = 0; return; end
`endif
    if (mq.size() == DEPTH) exp_ovf = 1;
    else mq.push_back(b);
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2k_data = b;
    repeat (5) @(negedge clk);
    ps2k_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2k_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Drives one full frame; lat = negedges after the stop fall until code_valid.
  task automatic rx(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                    input bit pop_at_push, output int lat);
    logic par;
    par = ~(^b) ^ bad_par;
    model_frame(b, bad_par, bad_stop, pop_at_push);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    @(negedge clk); ps2k_data = ~bad_stop;
    repeat (5) @(negedge clk);
    ps2k_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (lat == 0 && code_valid === 1'b1) lat = k;
      if (pop_at_push) code_ready = (k == 2);
    end
    ps2k_clk = 1'b1;
    ps2k_data = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    exp_ovf = 0; exp_par = 0; exp_frm = 0;
  endtask

  task automatic test_reset();
    n_vec++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", code_valid); end
    n_vec++; if (code_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", code_data); end
    n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_vec++; if ({overflow, parity_err, frame_err} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {overflow, parity_err, frame_err}); end
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", interrupt); end
  endtask

  task automatic test_single();
    int lat;
    rx(8'h1C, 0, 0, 0, lat);
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL t1_latency: got %0d want 3", lat); end
    n_vec++; if (code_valid !== 1'b1 || code_data !== 8'h1C) begin n_err++; $display("FAIL t1_head: got v=%b d=%h want v=1 d=1c", code_valid, code_data); end
    n_vec++; if (fifo_count !== 5'd1 || interrupt !== 1'b1) begin n_err++; $display("FAIL t1_count_irq: got %0d/%b want 1/1", fifo_count, interrupt); end
    void'(mq.pop_front());
    code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
    n_vec++; if (code_valid !== 1'b0 || interrupt !== 1'b0 || fifo_count !== 5'd0) begin n_err++; $display("FAIL t1_after_pop: got v=%b irq=%b cnt=%0d want 0/0/0", code_valid, interrupt, fifo_count); end
    n_vec++; if (code_data !== 8'h1C) begin n_err++; $display("FAIL t1_hold: got %h want 1c", code_data); end
    code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
    n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL t1_empty_pop: got %0d want 0", fifo_count); end
  endtask

  task automatic test_errors();
    int lat;
    rx(8'h1C, 1, 0, 0, lat);
    n_vec++; if (fifo_count !== 5'd0 || parity_err !== 1'b1 || frame_err !== 1'b0) begin n_err++; $display("FAIL t2_parity: got cnt=%0d par=%b frm=%b want 0/1/0", fifo_count, parity_err, frame_err); end
    clear_errors();
    n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL t2_clear: got %b want 0", parity_err); end
    rx(8'h5A, 0, 1, 0, lat);
    n_vec++; if (fifo_count !== 5'd0 || frame_err !== 1'b1 || parity_err !== 1'b0) begin n_err++; $display("FAIL t2_stop: got cnt=%0d frm=%b par=%b want 0/1/0", fifo_count, frame_err, parity_err); end
    clear_errors();
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL t2_clear_frm: got %b want 0", frame_err); end
  endtask

  task automatic test_overflow();
    int lat;
    logic [7:0] e;
    for (int i = 1; i <= 17; i++) rx(8'(i), 0, 0, 0, lat);
    n_vec++; if (fifo_count !== 5'd16 || overflow !== 1'b1) begin n_err++; $display("FAIL t3_full: got cnt=%0d ovf=%b want 16/1", fifo_count, overflow); end
    for (int i = 1; i <= 16; i++) begin
      e = mq.pop_front();
      n_vec++; if (code_valid !== 1'b1 || code_data !== e) begin n_err++; $display("FAIL t3_pop: got v=%b d=%h want v=1 d=%h", code_valid, code_data, e); end
      code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
    end
    n_vec++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL t3_drained: got %b want 0", code_valid); end
    clear_errors();
  endtask

  task automatic test_full_pop();
    int lat;
    logic [7:0] e;
    for (int i = 0; i < DEPTH; i++) rx(8'($urandom), 0, 0, 0, lat);
    rx(8'hA5, 0, 0, 1, lat);
    n_vec++; if (fifo_count !== 5'd16 || overflow !== 1'b0) begin n_err++; $display("FAIL t4_full_pop: got cnt=%0d ovf=%b want 16/0", fifo_count, overflow); end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      n_vec++; if (code_valid !== 1'b1 || code_data !== e) begin n_err++; $display("FAIL t4_pop: got v=%b d=%h want v=1 d=%h", code_valid, code_data, e); end
      code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
    end
    n_vec++; if (code_data !== 8'hA5) begin n_err++; $display("FAIL t4_last: got %h want a5", code_data); end
  endtask

  task automatic test_timeout();
    int lat;
    logic [7:0] e;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO - 60) @(negedge clk);
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL t5_early: got %b want 0", frame_err); end
    repeat (100) @(negedge clk);
    exp_frm = 1; drop = 0;
    n_vec++; if (frame_err !== 1'b1 || fifo_count !== 5'd0) begin n_err++; $display("FAIL t5_abort: got frm=%b cnt=%0d want 1/0", frame_err, fifo_count); end
    clear_errors();
    rx(8'h2A, 0, 0, 0, lat);
    e = mq.pop_front();
    n_vec++; if (code_valid !== 1'b1 || code_data !== e || frame_err !== 1'b0) begin n_err++; $display("FAIL t5_next: got v=%b d=%h frm=%b want 1/%h/0", code_valid, code_data, frame_err, e); end
    code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
  endtask

  task automatic test_sequence();
    int lat;
    int want_n;
    logic [7:0] seq [5];
    logic [7:0] e;
    seq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75};
`ifdef PS2_BREAK_FILTER_EN
    want_n = 3;
`else
    want_n = 5;
`endif
    for (int i = 0; i < 5; i++) rx(seq[i], 0, 0, 0, lat);
    n_vec++; if (fifo_count !== 5'(want_n)) begin n_err++; $display("FAIL t6_count: got %0d want %0d", fifo_count, want_n); end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      n_vec++; if (code_valid !== 1'b1 || code_data !== e) begin n_err++; $display("FAIL t6_pop: got v=%b d=%h want v=1 d=%h", code_valid, code_data, e); end
      code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    int lat, sel, npop;
    logic [7:0] e;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      rx(8'($urandom), sel == 0, sel == 1, 0, lat);
      n_vec++;
      if (fifo_count !== 5'(mq.size()) || interrupt !== (mq.size() >= IRQ) ||
          {overflow, parity_err, frame_err} !== {exp_ovf, exp_par, exp_frm}) begin
        n_err++;
        $display("FAIL rnd_state it=%0d: got cnt=%0d irq=%b flags=%b want cnt=%0d irq=%b flags=%b",
                 it, fifo_count, interrupt, {overflow, parity_err, frame_err},
                 mq.size(), mq.size() >= IRQ, {exp_ovf, exp_par, exp_frm});
      end
      npop = $urandom_range(0, 1);
      for (int p = 0; p < npop && mq.size() > 0; p++) begin
        e = mq.pop_front();
        n_vec++; if (code_valid !== 1'b1 || code_data !== e) begin n_err++; $display("FAIL rnd_pop it=%0d: got v=%b d=%h want v=1 d=%h", it, code_valid, code_data, e); end
        code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) clear_errors();
    end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      n_vec++; if (code_valid !== 1'b1 || code_data !== e) begin n_err++; $display("FAIL rnd_drain: got v=%b d=%h want v=1 d=%h", code_valid, code_data, e); end
      code_ready = 1'b1; @(negedge clk); code_ready = 1'b0;
    end
    clear_errors();
  endtask

  task automatic test_reset_midframe();
    int lat;
    logic [7:0] e;
    rx(8'h11, 0, 0, 0, lat);
    rx(8'h22, 1, 0, 0, lat);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (code_valid !== 1'b0 || code_data !== 8'h00 || fifo_count !== 5'd0 || interrupt !== 1'b0 ||
        {overflow, parity_err, frame_err} !== 3'b000) begin
      n_err++;
      $display("FAIL midframe_rst: got v=%b d=%h cnt=%0d irq=%b flags=%b want all zero",
               code_valid, code_data, fifo_count, interrupt, {overflow, parity_err, frame_err});
    end
    mq.delete(); exp_ovf = 0; exp_par = 0; exp_frm = 0; drop = 0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rx(8'h33, 0, 0, 0, lat);
    e = mq.pop_front();
    n_vec++;
    if (code_valid !== 1'b1 || code_data !== e || fifo_count !== 5'd1 ||
        {parity_err, frame_err} !== 2'b00) begin
      n_err++;
      $display("FAIL post_rst_frame: got v=%b d=%h cnt=%0d flags=%b want 1/%h/1/00",
               code_valid, code_data, fifo_count, {parity_err, frame_err}, e);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_errors();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_sequence();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
